// File: rtl/grf_mp_if.sv
// Register-file access bundle: write ports, read ports, allocation and scoreboard status.
interface grf_mp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NRD    = 2
);
    logic                  we0;
    logic [ADDR_W-1:0]     waddr0;
    logic [DATA_W-1:0]     wdata0;
    logic                  we1;
    logic [ADDR_W-1:0]     waddr1;
    logic [DATA_W-1:0]     wdata1;
    logic [NRD*ADDR_W-1:0] raddr;
    logic [NRD*DATA_W-1:0] rdata;
    logic [NRD-1:0]        rbusy;
    logic                  alloc_en;
    logic [ADDR_W-1:0]     alloc_addr;
    logic [ADDR_W:0]       busy_cnt;

    // Pipeline side: decode/writeback drive requests and observe data and hazards.
    modport master (
        output we0, waddr0, wdata0, we1, waddr1, wdata1, raddr, alloc_en, alloc_addr,
        input  rdata, rbusy, busy_cnt
    );

    // Register-file side.
    modport slave (
        input  we0, waddr0, wdata0, we1, waddr1, wdata1, raddr, alloc_en, alloc_addr,
        output rdata, rbusy, busy_cnt
    );
endinterface

// File: rtl/grf_mp.sv
// General register file: NRD combinational read ports with write bypass,
// two write ports (port 1 is the younger instruction and wins), and a
// per-register busy scoreboard with a registered busy count.
module grf_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1
) (
    input  logic       clk,
    input  logic       reset,
    grf_mp_if.slave    bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CNT_W = ADDR_W + 1;

    // True when the address names the hard-wired zero register.
    function automatic logic is_zero(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == {ADDR_W{1'b0}});
    endfunction

    // Number of set bits in the busy vector.
    function automatic logic [CNT_W-1:0] popcount(input logic [DEPTH-1:0] v);
        logic [CNT_W-1:0] c;
        c = {CNT_W{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            c = c + {{(CNT_W-1){1'b0}}, v[i]};
        end
        return c;
    endfunction

    logic [DATA_W-1:0]     regs_q [DEPTH];
    logic [DEPTH-1:0]      busy_q;
    logic [DEPTH-1:0]      busy_d;
    logic [CNT_W-1:0]      busy_cnt_q;
    logic [CNT_W-1:0]      busy_cnt_d;
    logic                  wr0_s;
    logic                  wr1_s;
    logic [ADDR_W-1:0]     ra_s;
    logic [NRD*DATA_W-1:0] rdata_s;
    logic [NRD-1:0]        rbusy_s;

    // Effective write strobes: the zero register swallows writes.
    always_comb begin
        wr0_s = bus.we0 & ~is_zero(bus.waddr0);
        wr1_s = bus.we1 & ~is_zero(bus.waddr1);
    end

    // Read ports: zero register, then younger write, then older write, then array.
    // Bypass is suppressed during reset because those writes will not land.
    always_comb begin
        rdata_s = {(NRD*DATA_W){1'b0}};
        rbusy_s = {NRD{1'b0}};
        ra_s    = {ADDR_W{1'b0}};
        for (int k = 0; k < NRD; k++) begin
            ra_s = bus.raddr[k*ADDR_W +: ADDR_W];
            if (is_zero(ra_s)) begin
                rdata_s[k*DATA_W +: DATA_W] = {DATA_W{1'b0}};
                rbusy_s[k]                  = 1'b0;
            end else if (!reset && bus.we1 && (bus.waddr1 == ra_s)) begin
                rdata_s[k*DATA_W +: DATA_W] = bus.wdata1;
                rbusy_s[k]                  = 1'b0;
            end else if (!reset && bus.we0 && (bus.waddr0 == ra_s)) begin
                rdata_s[k*DATA_W +: DATA_W] = bus.wdata0;
                rbusy_s[k]                  = 1'b0;
            end else begin
                rdata_s[k*DATA_W +: DATA_W] = regs_q[ra_s];
                rbusy_s[k]                  = busy_q[ra_s];
            end
        end
    end

    // Scoreboard next state: writes release, allocation sets last so a new producer wins.
    always_comb begin
        busy_d = busy_q;
        if (wr0_s) begin
            busy_d[bus.waddr0] = 1'b0;
        end else begin
            busy_d = busy_d;
        end
        if (wr1_s) begin
            busy_d[bus.waddr1] = 1'b0;
        end else begin
            busy_d = busy_d;
        end
        if (bus.alloc_en && !is_zero(bus.alloc_addr)) begin
            busy_d[bus.alloc_addr] = 1'b1;
        end else begin
            busy_d = busy_d;
        end
        busy_cnt_d = popcount(busy_d);
    end

    // Register array: port 1 assigned last so it wins a same-address conflict.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= {DATA_W{1'b0}};
            end
        end else begin
            if (wr0_s) begin
                regs_q[bus.waddr0] <= bus.wdata0;
            end
            if (wr1_s) begin
                regs_q[bus.waddr1] <= bus.wdata1;
            end
        end
    end

    // Scoreboard and busy count state.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q     <= {DEPTH{1'b0}};
            busy_cnt_q <= {CNT_W{1'b0}};
        end else begin
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign bus.rdata    = rdata_s;
    assign bus.rbusy    = rbusy_s;
    assign bus.busy_cnt = busy_cnt_q;
endmodule

// File: tb/tb_grf_mp.sv
// Directed self-checking bench for grf_mp (32x32, two read ports, zero register on).
module tb_grf_mp;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    grf_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR)) bus ();

    grf_mp #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR), .ZERO_REG(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.we0 = 1'b0; bus.waddr0 = 5'd0; bus.wdata0 = 32'd0;
        bus.we1 = 1'b0; bus.waddr1 = 5'd0; bus.wdata1 = 32'd0;
        bus.alloc_en = 1'b0; bus.alloc_addr = 5'd0;
    endtask

    task automatic set_ra(input int k, input logic [4:0] a);
        bus.raddr[k*AW +: AW] = a;
    endtask

    function automatic logic [31:0] rd(input int k);
        return bus.rdata[k*DW +: DW];
    endfunction

    // Advance to the next falling edge, where inputs change and outputs are stable.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b1;
        bus.raddr = '0;
        idle();
        tick();
        tick();
        reset = 1'b0;

        // 1. Reset state on every address and port
        for (int a = 0; a < 32; a++) begin
            set_ra(0, 5'(a));
            set_ra(1, 5'(31 - a));
            #1;
            chk($sformatf("rst_rd0_a%0d", a), rd(0), 32'd0);
            chk($sformatf("rst_rd1_a%0d", a), rd(1), 32'd0);
            chk($sformatf("rst_rbusy_a%0d", a), {30'd0, bus.rbusy}, 32'd0);
        end
        chk("rst_cnt", {26'd0, bus.busy_cnt}, 32'd0);

        // 2. Bypass then array read
        tick();
        bus.we0 = 1'b1; bus.waddr0 = 5'd5; bus.wdata0 = 32'h1234_5678;
        set_ra(0, 5'd5);
        #1 chk("byp0_same", rd(0), 32'h1234_5678);
        tick();
        idle();
        #1 chk("byp0_array", rd(0), 32'h1234_5678);

        // 3. Dual write same address, younger wins
        tick();
        bus.we0 = 1'b1; bus.waddr0 = 5'd7; bus.wdata0 = 32'hAAAA_AAAA;
        bus.we1 = 1'b1; bus.waddr1 = 5'd7; bus.wdata1 = 32'h5555_5555;
        set_ra(1, 5'd7);
        #1 chk("dual_same", rd(1), 32'h5555_5555);
        tick();
        idle();
        #1 chk("dual_array", rd(1), 32'h5555_5555);

        // 4. Zero register ignores write and alloc
        tick();
        bus.we0 = 1'b1; bus.waddr0 = 5'd0; bus.wdata0 = 32'hFFFF_FFFF;
        bus.alloc_en = 1'b1; bus.alloc_addr = 5'd0;
        set_ra(0, 5'd0);
        #1 chk("zero_same", rd(0), 32'd0);
        chk("zero_rbusy_same", {31'd0, bus.rbusy[0]}, 32'd0);
        tick();
        idle();
        #1 chk("zero_array", rd(0), 32'd0);
        chk("zero_rbusy", {31'd0, bus.rbusy[0]}, 32'd0);
        chk("zero_cnt", {26'd0, bus.busy_cnt}, 32'd0);

        // 5. Scoreboard
        bus.alloc_en = 1'b1; bus.alloc_addr = 5'd3;
        tick();
        bus.alloc_addr = 5'd9;
        tick();
        idle();
        set_ra(0, 5'd3);
        set_ra(1, 5'd9);
        #1 chk("sb_cnt2", {26'd0, bus.busy_cnt}, 32'd2);
        chk("sb_rbusy3", {31'd0, bus.rbusy[0]}, 32'd1);
        chk("sb_rbusy9", {31'd0, bus.rbusy[1]}, 32'd1);
        bus.alloc_en = 1'b1; bus.alloc_addr = 5'd3;
        tick();
        idle();
        #1 chk("sb_realloc_cnt", {26'd0, bus.busy_cnt}, 32'd2);
        bus.we0 = 1'b1; bus.waddr0 = 5'd3; bus.wdata0 = 32'h0000_0033;
        bus.alloc_en = 1'b1; bus.alloc_addr = 5'd3;
        #1 chk("sb_wr_byp_rbusy", {31'd0, bus.rbusy[0]}, 32'd0);
        tick();
        idle();
        #1 chk("sb_setwins_cnt", {26'd0, bus.busy_cnt}, 32'd2);
        chk("sb_setwins_rbusy", {31'd0, bus.rbusy[0]}, 32'd1);
        bus.we0 = 1'b1; bus.waddr0 = 5'd3; bus.wdata0 = 32'h0000_0333;
        bus.we1 = 1'b1; bus.waddr1 = 5'd9; bus.wdata1 = 32'h0000_0999;
        tick();
        idle();
        #1 chk("sb_rel_cnt", {26'd0, bus.busy_cnt}, 32'd0);
        chk("sb_rel_rbusy", {30'd0, bus.rbusy}, 32'd0);
        chk("sb_rel_d3", rd(0), 32'h0000_0333);
        chk("sb_rel_d9", rd(1), 32'h0000_0999);
        bus.we0 = 1'b1; bus.waddr0 = 5'd12; bus.wdata0 = 32'h0000_0012;
        tick();
        idle();
        #1 chk("sb_nonbusy_cnt", {26'd0, bus.busy_cnt}, 32'd0);

        // 6. Fill, allocate, then reset with a write in the reset cycle
        for (int a = 1; a < 32; a++) begin
            bus.we0 = 1'b1; bus.waddr0 = 5'(a); bus.wdata0 = 32'(a);
            tick();
        end
        idle();
        for (int a = 1; a <= 3; a++) begin
            bus.alloc_en = 1'b1; bus.alloc_addr = 5'(a * 4);
            tick();
        end
        idle();
        set_ra(0, 5'd17);
        set_ra(1, 5'd8);
        #1 chk("fill_r17", rd(0), 32'd17);
        chk("fill_cnt", {26'd0, bus.busy_cnt}, 32'd3);
        chk("fill_rbusy8", {31'd0, bus.rbusy[1]}, 32'd1);
        reset = 1'b1;
        bus.we0 = 1'b1; bus.waddr0 = 5'd10; bus.wdata0 = 32'hDEAD_BEEF;
        set_ra(0, 5'd10);
        #1 chk("rstcyc_nobyp", rd(0), 32'd10);
        tick();
        reset = 1'b0;
        idle();
        for (int a = 0; a < 32; a++) begin
            set_ra(0, 5'(a));
            set_ra(1, 5'(a));
            #1 chk($sformatf("post_rst_a%0d", a), rd(0), 32'd0);
            chk($sformatf("post_rst_rbusy_a%0d", a), {30'd0, bus.rbusy}, 32'd0);
        end
        chk("post_rst_cnt", {26'd0, bus.busy_cnt}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
